// File: rtl/keypad_scanner_pkg.sv
// Shared constants, key codes and key-map helpers for the keypad scanner.
package keypad_scanner_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 3;
    localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;

    typedef logic [3:0] key_code_t;

    localparam key_code_t KEY_STAR = 4'd10;
    localparam key_code_t KEY_HASH = 4'd11;
    localparam key_code_t KEY_NONE = 4'hF;

    // Key index is row*NUM_COLS + col; layout 1 2 3 / 4 5 6 / 7 8 9 / * 0 #.
    function automatic key_code_t key_of_index(input logic [3:0] idx);
        key_code_t code;
        case (idx)
            4'd0:    code = 4'd1;
            4'd1:    code = 4'd2;
            4'd2:    code = 4'd3;
            4'd3:    code = 4'd4;
            4'd4:    code = 4'd5;
            4'd5:    code = 4'd6;
            4'd6:    code = 4'd7;
            4'd7:    code = 4'd8;
            4'd8:    code = 4'd9;
            4'd9:    code = KEY_STAR;
            4'd10:   code = 4'd0;
            4'd11:   code = KEY_HASH;
            default: code = KEY_NONE;
        endcase
        return code;
    endfunction

    // Row of a key index.
    function automatic logic [1:0] row_of_index(input logic [3:0] idx);
        logic [3:0] row;
        row = idx / 4'd3;
        return row[1:0];
    endfunction

    // Column of a key index.
    function automatic logic [1:0] col_of_index(input logic [3:0] idx);
        logic [3:0] col;
        col = idx % 4'd3;
        return col[1:0];
    endfunction

    // One-hot digit vector; non-digit codes give all zeros.
    function automatic logic [9:0] digit_onehot(input key_code_t code);
        logic [9:0] vec;
        if (code <= 4'd9) begin
            vec = 10'b00_0000_0001 << code;
        end else begin
            vec = 10'b00_0000_0000;
        end
        return vec;
    endfunction

endpackage

// File: rtl/keypad_scanner_debounce.sv
// Whole-scan debouncer: a new key code is accepted once it has been seen on
// DEBOUNCE_SCANS consecutive scans. Release (KEY_NONE) is handled the same way.
module keypad_debounce
    import keypad_scanner_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 2
) (
    input  logic      clock,
    input  logic      reset,
    input  logic      scan_done,
    input  key_code_t code,
    output key_code_t debounced,
    output logic      changed
);

    localparam int CNT_W = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_SCANS);

    key_code_t        candidate_r;
    key_code_t        debounced_r;
    logic [CNT_W-1:0] count_r;

    key_code_t        candidate_s;
    logic [CNT_W-1:0] count_s;
    logic             accept_s;

    // Next candidate/run-length and acceptance decision for this scan end.
    always_comb begin
        candidate_s = candidate_r;
        count_s     = count_r;
        accept_s    = 1'b0;
        if (scan_done) begin
            if (code == candidate_r) begin
                count_s = (count_r == CNT_MAX) ? count_r : count_r + CNT_W'(1);
            end else begin
                candidate_s = code;
                count_s     = CNT_W'(1);
            end
            accept_s = (count_s == CNT_MAX) && (candidate_s != debounced_r);
        end else begin
            accept_s = 1'b0;
        end
    end

    // Debounce state registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            candidate_r <= KEY_NONE;
            count_r     <= '0;
            debounced_r <= KEY_NONE;
        end else begin
            candidate_r <= candidate_s;
            count_r     <= count_s;
            if (accept_s) begin
                debounced_r <= candidate_s;
            end
        end
    end

    // The next debounced value is exposed so the caller can register it in the same edge.
    assign debounced = accept_s ? candidate_s : debounced_r;
    assign changed   = accept_s;

endmodule

// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad scanner with debouncing, driving the microwave front-panel
// levels: one-hot keypad digits plus active-low start ('#') and clear ('*').
module keypad_scanner
    import keypad_scanner_pkg::*;
#(
    parameter int ROW_CYCLES     = 3,
    parameter int DEBOUNCE_SCANS = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] col_n,
    output logic [3:0] row_n,
    output logic [9:0] keypad,
    output logic       startn,
    output logic       clearn,
    output logic       key_event
);

    localparam int TICK_W = (ROW_CYCLES > 1) ? $clog2(ROW_CYCLES) : 1;
    localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(ROW_CYCLES - 1);

    logic [2:0]        col_meta_r;
    logic [2:0]        col_sync_r;
    logic [1:0]        row_r;
    logic [TICK_W-1:0] tick_r;
    logic [3:0]        row_n_r;
    logic [11:0]       snapshot_r;
    logic [9:0]        keypad_r;
    logic              startn_r;
    logic              clearn_r;
    logic              key_event_r;

    logic              last_tick_s;
    logic              scan_done_s;
    logic [3:0]        row_base_s;
    logic [11:0]       snapshot_s;
    logic [3:0]        ones_s;
    logic [3:0]        idx_s;
    key_code_t         scan_code_s;
    key_code_t         debounced_s;
    logic              changed_s;

    // Two-flop synchronizer on the column inputs (idle level is all ones).
    always_ff @(posedge clock) begin
        if (reset) begin
            col_meta_r <= 3'b111;
            col_sync_r <= 3'b111;
        end else begin
            col_meta_r <= col_n;
            col_sync_r <= col_meta_r;
        end
    end

    assign last_tick_s = (tick_r == LAST_TICK);
    assign scan_done_s = last_tick_s && (row_r == 2'd3);

    // Row/tick counters; row drive is kept registered alongside the row count.
    always_ff @(posedge clock) begin
        if (reset) begin
            row_r   <= 2'd0;
            tick_r  <= '0;
            row_n_r <= 4'b1110;
        end else if (last_tick_s) begin
            tick_r  <= '0;
            row_r   <= row_r + 2'd1;
            row_n_r <= ~(4'b0001 << (row_r + 2'd1));
        end else begin
            tick_r  <= tick_r + TICK_W'(1);
        end
    end

    assign row_base_s = {2'b00, row_r} * 4'd3;

    // Snapshot including the row being captured this cycle, so decode sees row 3 too.
    always_comb begin
        snapshot_s = snapshot_r;
        if (last_tick_s) begin
            snapshot_s[row_base_s +: 3] = ~col_sync_r;
        end else begin
            snapshot_s = snapshot_r;
        end
    end

    // Pressed-key snapshot register.
    always_ff @(posedge clock) begin
        if (reset) begin
            snapshot_r <= 12'h000;
        end else begin
            snapshot_r <= snapshot_s;
        end
    end

    // Decode: exactly one key down gives its code; none or several give KEY_NONE.
    always_comb begin
        ones_s = 4'd0;
        idx_s  = 4'd0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            ones_s = ones_s + {3'b000, snapshot_s[i]};
            idx_s  = snapshot_s[i] ? 4'(i) : idx_s;
        end
        scan_code_s = (ones_s == 4'd1) ? key_of_index(idx_s) : KEY_NONE;
    end

    keypad_debounce #(
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_debounce (
        .clock    (clock),
        .reset    (reset),
        .scan_done(scan_done_s),
        .code     (scan_code_s),
        .debounced(debounced_s),
        .changed  (changed_s)
    );

    // Registered front-panel outputs derived from the debounced key.
    always_ff @(posedge clock) begin
        if (reset) begin
            keypad_r    <= 10'b00_0000_0000;
            startn_r    <= 1'b1;
            clearn_r    <= 1'b1;
            key_event_r <= 1'b0;
        end else begin
            keypad_r    <= digit_onehot(debounced_s);
            startn_r    <= (debounced_s != KEY_HASH);
            clearn_r    <= (debounced_s != KEY_STAR);
            key_event_r <= changed_s && (debounced_s != KEY_NONE);
        end
    end

    assign row_n     = row_n_r;
    assign keypad    = keypad_r;
    assign startn    = startn_r;
    assign clearn    = clearn_r;
    assign key_event = key_event_r;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a simulated key matrix plus a
// scan-level reference model (sliding window over per-scan key codes).
module tb_keypad_scanner;

    localparam int D = 2;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] col_n;
    logic [3:0] row_n;
    logic [9:0] keypad;
    logic       startn;
    logic       clearn;
    logic       key_event;

    int checks   = 0;
    int failures = 0;

    keypad_scanner #(.ROW_CYCLES(3), .DEBOUNCE_SCANS(D)) dut (
        .clock    (clock),
        .reset    (reset),
        .col_n    (col_n),
        .row_n    (row_n),
        .keypad   (keypad),
        .startn   (startn),
        .clearn   (clearn),
        .key_event(key_event)
    );

    always #5 clock = ~clock;

    // Held keys, bit = row*3 + col of the physical matrix.
    logic [11:0] held = 12'h000;

    // Physical matrix: a held key pulls its column low while its row is driven.
    always_comb begin
        col_n = 3'b111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 3; c++)
                if (!row_n[r] && held[r*3+c]) col_n[c] = 1'b0;
    end

    // Key legend by matrix position: 1 2 3 / 4 5 6 / 7 8 9 / *(10) 0 #(11).
    int legend [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 0, 11};

    function automatic logic [11:0] key_bit(input int key);
        logic [11:0] b;
        b = 12'h000;
        for (int i = 0; i < 12; i++) if (legend[i] == key) b[i] = 1'b1;
        return b;
    endfunction

    function automatic int model_code(input logic [11:0] s);
        int n, k;
        n = 0; k = 15;
        for (int i = 0; i < 12; i++) if (s[i]) begin n++; k = legend[i]; end
        return (n == 1) ? k : 15;
    endfunction

    // Reference model state.
    int hist[$];
    int deb_m = 15;
    logic       exp_ev;
    logic [9:0] exp_kp;
    logic       exp_startn, exp_clearn;

    // Observations of the last scan.
    logic [3:0] rows_obs [12];
    int         ev_cnt;
    logic       ev_last;
    int         early_chg;
    int         scan_no = 0;

    task automatic model_reset();
        hist.delete();
        deb_m = 15;
        exp_kp = 10'h000; exp_startn = 1'b1; exp_clearn = 1'b1; exp_ev = 1'b0;
    endtask

    // Reset the DUT for one edge and release; samples at #1 after that edge.
    task automatic do_reset();
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        model_reset();
    endtask

    // Drive one full 12-cycle scan with a given held set, recording observations.
    task automatic run_scan(input logic [11:0] s);
        logic [9:0] kp0;
        logic all_eq;
        int code;
        held = s;
        kp0 = keypad;
        ev_cnt = 0; ev_last = 1'b0; early_chg = 0;
        for (int j = 1; j <= 12; j++) begin
            @(posedge clock); #1;
            rows_obs[j-1] = row_n;
            if (key_event) ev_cnt++;
            if (j == 12) ev_last = key_event;
            if (j < 12 && keypad !== kp0) early_chg++;
        end
        scan_no++;
        code = model_code(s);
        hist.push_back(code);
        if (hist.size() > D) void'(hist.pop_front());
        exp_ev = 1'b0;
        if (hist.size() == D) begin
            all_eq = 1'b1;
            foreach (hist[k]) if (hist[k] != code) all_eq = 1'b0;
            if (all_eq && code != deb_m) begin
                deb_m = code;
                exp_ev = (code != 15);
            end
        end
        exp_kp = (deb_m <= 9) ? (10'h001 << deb_m) : 10'h000;
        exp_startn = (deb_m != 11);
        exp_clearn = (deb_m != 10);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({row_n, keypad, startn, clearn, key_event} !== {4'b1110, 10'h000, 1'b1, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL reset_state row_n=%b keypad=%h startn=%b clearn=%b key_event=%b required 1110 000 1 1 0",
                     row_n, keypad, startn, clearn, key_event);
        end
        run_scan(12'h000);
        for (int j = 1; j <= 12; j++) begin
            checks++;
            if (rows_obs[j-1] !== ~(4'b0001 << ((j % 12) / 3))) begin
                failures++;
                $display("FAIL row_step cycle=%0d row_n=%b required %b", j, rows_obs[j-1], ~(4'b0001 << ((j % 12) / 3)));
            end
        end
    endtask

    task automatic test_single_digit();
        int evs;
        evs = 0;
        for (int n = 0; n < 6; n++) begin
            run_scan(n < 3 ? key_bit(5) : 12'h000);
            evs += ev_cnt;
            checks++;
            if ({keypad, startn, clearn} !== {exp_kp, exp_startn, exp_clearn} || ev_cnt !== int'(exp_ev)
                || ev_last !== exp_ev || early_chg !== 0) begin
                failures++;
                $display("FAIL digit5 scan=%0d keypad=%h ev=%0d early=%0d required keypad=%h ev=%0d",
                         n, keypad, ev_cnt, early_chg, exp_kp, exp_ev);
            end
            if (n == 2) begin
                checks++;
                if (keypad !== 10'b00_0010_0000) begin
                    failures++;
                    $display("FAIL digit5_held keypad=%h required 020", keypad);
                end
            end
        end
        checks++;
        if (keypad !== 10'h000 || evs !== 1) begin
            failures++;
            $display("FAIL digit5_release keypad=%h events=%0d required 000 1", keypad, evs);
        end
    endtask

    task automatic test_start_clear();
        logic [11:0] seq [9];
        seq = '{key_bit(11), key_bit(11), key_bit(11), key_bit(10), key_bit(10), key_bit(10),
                12'h000, 12'h000, 12'h000};
        for (int n = 0; n < 9; n++) begin
            run_scan(seq[n]);
            checks++;
            if ({keypad, startn, clearn} !== {exp_kp, exp_startn, exp_clearn} || ev_cnt !== int'(exp_ev)
                || ev_last !== exp_ev) begin
                failures++;
                $display("FAIL start_clear scan=%0d keypad=%h startn=%b clearn=%b ev=%0d required %h %b %b %0d",
                         n, keypad, startn, clearn, ev_cnt, exp_kp, exp_startn, exp_clearn, exp_ev);
            end
            if (n == 2 || n == 5) begin
                checks++;
                if ({keypad, startn, clearn} !== ((n == 2) ? {10'h000, 1'b0, 1'b1} : {10'h000, 1'b1, 1'b0})) begin
                    failures++;
                    $display("FAIL start_clear_held scan=%0d keypad=%h startn=%b clearn=%b", n, keypad, startn, clearn);
                end
            end
        end
        checks++;
        if (startn !== 1'b1 || clearn !== 1'b1) begin
            failures++;
            $display("FAIL start_clear_release startn=%b clearn=%b required 1 1", startn, clearn);
        end
    endtask

    task automatic test_two_keys();
        int evs;
        evs = 0;
        for (int n = 0; n < 4; n++) begin
            run_scan(key_bit(1) | key_bit(2));
            evs += ev_cnt;
        end
        run_scan(12'h000);
        evs += ev_cnt;
        checks++;
        if (keypad !== 10'h000 || startn !== 1'b1 || clearn !== 1'b1 || evs !== 0) begin
            failures++;
            $display("FAIL two_keys keypad=%h startn=%b clearn=%b events=%0d required 000 1 1 0",
                     keypad, startn, clearn, evs);
        end
    endtask

    task automatic test_glitch_then_switch();
        logic [11:0] seq [10];
        int evs;
        logic [9:0] seen [$];
        seq = '{key_bit(9), 12'h000, 12'h000, 12'h000, key_bit(5), key_bit(5), key_bit(5),
                key_bit(7), key_bit(7), key_bit(7)};
        evs = 0;
        for (int n = 0; n < 10; n++) begin
            run_scan(seq[n]);
            if (n >= 4) evs += ev_cnt;
            if (seen.size() == 0 || seen[$] !== keypad) seen.push_back(keypad);
            checks++;
            if (keypad !== exp_kp || ev_cnt !== int'(exp_ev) || ev_last !== exp_ev) begin
                failures++;
                $display("FAIL glitch_switch scan=%0d keypad=%h ev=%0d required %h %0d", n, keypad, ev_cnt, exp_kp, exp_ev);
            end
            if (n < 4) begin
                checks++;
                if (keypad !== 10'h000 || ev_cnt !== 0) begin
                    failures++;
                    $display("FAIL glitch9 scan=%0d keypad=%h ev=%0d required 000 0", n, keypad, ev_cnt);
                end
            end
        end
        checks++;
        if (seen.size() !== 3 || seen[1] !== 10'h020 || seen[2] !== 10'h080 || evs !== 2) begin
            failures++;
            $display("FAIL switch_5_7 values=%0d events=%0d last=%h required 3 2 080", seen.size(), evs, keypad);
        end
    endtask

    task automatic test_reset_mid_scan();
        for (int n = 0; n < 3; n++) run_scan(key_bit(0));
        checks++;
        if (keypad !== 10'b00_0000_0001) begin
            failures++;
            $display("FAIL zero_held keypad=%h required 001", keypad);
        end
        repeat (5) @(posedge clock);
        #1;
        do_reset();
        checks++;
        if (keypad !== 10'h000 || row_n !== 4'b1110 || key_event !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid keypad=%h row_n=%b key_event=%b required 000 1110 0", keypad, row_n, key_event);
        end
        for (int n = 0; n < 3; n++) begin
            run_scan(key_bit(0));
            checks++;
            if (keypad !== exp_kp || ev_cnt !== int'(exp_ev)) begin
                failures++;
                $display("FAIL reset_recover scan=%0d keypad=%h ev=%0d required %h %0d", n, keypad, ev_cnt, exp_kp, exp_ev);
            end
        end
        checks++;
        if (keypad !== 10'h001) begin
            failures++;
            $display("FAIL zero_return keypad=%h required 001", keypad);
        end
    endtask

    task automatic test_random();
        logic [11:0] s;
        int a, b, reps;
        for (int seg = 0; seg < 30; seg++) begin
            a = $urandom_range(0, 11);
            b = $urandom_range(0, 11);
            case ($urandom_range(0, 3))
                0:       s = 12'h000;
                1, 2:    s = 12'h001 << a;
                default: s = (12'h001 << a) | (12'h001 << ((a + 1 + (b % 11)) % 12));
            endcase
            reps = $urandom_range(1, 3);
            for (int r = 0; r < reps; r++) begin
                run_scan(s);
                checks++;
                if ({keypad, startn, clearn} !== {exp_kp, exp_startn, exp_clearn} || ev_cnt !== int'(exp_ev)
                    || ev_last !== exp_ev || early_chg !== 0) begin
                    failures++;
                    $display("FAIL random scan=%0d held=%h keypad=%h startn=%b clearn=%b ev=%0d required %h %b %b %0d",
                             scan_no, s, keypad, startn, clearn, ev_cnt, exp_kp, exp_startn, exp_clearn, exp_ev);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_digit();
        test_start_clear();
        test_two_keys();
        test_glitch_then_switch();
        test_reset_mid_scan();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
